// File: rtl/ttt_pkg.sv
// Shared types and encodings for the N x N tic-tac-toe controller.
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    localparam logic [1:0] NONE   = 2'b00;
    localparam logic [1:0] WIN_P1 = 2'b01;
    localparam logic [1:0] WIN_P2 = 2'b10;
    localparam logic [1:0] DRAW   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MOVE,
        CHECK,
        OVER
    } state_t;

    // Player bit (0 = P1, 1 = P2) to the cell code it writes.
    function automatic cell_t player_cell(input logic player);
        return player ? P2 : P1;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win/draw detector for an N x N board: every row, column and
// both diagonals are scanned for N equal non-empty cells.
module ttt_line_check
    import ttt_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [2*N*N-1:0] board_i,
    output logic             win_o,
    output logic [1:0]       win_player_o,
    output logic             full_o
);

    logic [1:0] lead;
    logic       same;

    // Scan all 2N+2 lines; a line wins when every cell equals its first cell and that cell is set.
    always_comb begin
        win_o        = 1'b0;
        win_player_o = EMPTY;
        full_o       = 1'b1;
        lead         = EMPTY;
        same         = 1'b0;

        for (int i = 0; i < N * N; i++) begin
            if (board_i[2*i +: 2] == EMPTY) full_o = 1'b0;
        end

        for (int r = 0; r < N; r++) begin
            lead = board_i[2*(r*N) +: 2];
            same = 1'b1;
            for (int c = 1; c < N; c++) begin
                if (board_i[2*(r*N+c) +: 2] != lead) same = 1'b0;
            end
            if (same && lead != EMPTY) begin
                win_o        = 1'b1;
                win_player_o = lead;
            end
        end

        for (int c = 0; c < N; c++) begin
            lead = board_i[2*c +: 2];
            same = 1'b1;
            for (int r = 1; r < N; r++) begin
                if (board_i[2*(r*N+c) +: 2] != lead) same = 1'b0;
            end
            if (same && lead != EMPTY) begin
                win_o        = 1'b1;
                win_player_o = lead;
            end
        end

        lead = board_i[1:0];
        same = 1'b1;
        for (int k = 1; k < N; k++) begin
            if (board_i[2*(k*N+k) +: 2] != lead) same = 1'b0;
        end
        if (same && lead != EMPTY) begin
            win_o        = 1'b1;
            win_player_o = lead;
        end

        lead = board_i[2*(N-1) +: 2];
        same = 1'b1;
        for (int k = 1; k < N; k++) begin
            if (board_i[2*(k*N+(N-1-k)) +: 2] != lead) same = 1'b0;
        end
        if (same && lead != EMPTY) begin
            win_o        = 1'b1;
            win_player_o = lead;
        end
    end

endmodule

// File: rtl/ttt_grid_ctrl.sv
// N x N tic-tac-toe game controller: board storage, turn/legality
// enforcement and win/draw resolution one cycle after each accepted move.
// Optional per-turn forfeit timer is compiled in with `define TTT_TURN_TIMER_EN.
module ttt_grid_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned N           = 3,
    parameter int unsigned TURN_CYCLES = 1000,
    localparam int unsigned PW         = $clog2(N*N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_pulse,
    input  logic             move_valid,
    input  logic             move_player,
    input  logic [PW-1:0]    move_pos,
    output logic [2*N*N-1:0] board,
    output logic             turn,
    output logic [1:0]       winner,
    output logic             game_over,
    output logic             move_error,
    output logic             timeout_pulse
);

    state_t            state_q;
    logic [2*N*N-1:0]  board_q;
    logic              turn_q;
    logic [1:0]        winner_q;
    logic              game_over_q;
    logic              move_error_q;

    logic              pos_ok;
    logic [1:0]        cell_sel;
    logic              accept;
    logic              expire;
    logic              line_win;
    logic [1:0]        line_player;
    logic              board_full;

    // Decode move_pos against the board; indices >= N*N never match.
    always_comb begin
        pos_ok   = 1'b0;
        cell_sel = EMPTY;
        for (int i = 0; i < N * N; i++) begin
            if (move_pos == PW'(i)) begin
                pos_ok   = 1'b1;
                cell_sel = board_q[2*i +: 2];
            end
        end
    end

    assign accept = (state_q == WAIT_MOVE) && move_valid && (move_player == turn_q) &&
                    pos_ok && (cell_sel == EMPTY);

    ttt_line_check #(
        .N (N)
    ) u_line_check (
        .board_i      (board_q),
        .win_o        (line_win),
        .win_player_o (line_player),
        .full_o       (board_full)
    );

`ifdef TTT_TURN_TIMER_EN
    localparam int unsigned TW = $clog2(TURN_CYCLES + 1);

    logic [TW-1:0] timer_q;
    logic          timeout_q;

    // An accepted move on the expiry cycle takes precedence over the forfeit.
    assign expire = (state_q == WAIT_MOVE) && !start_pulse && !accept &&
                    (timer_q == TW'(TURN_CYCLES - 1));

    // Turn timer: held at zero outside WAIT_MOVE so every entry starts fresh.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (start_pulse || state_q != WAIT_MOVE || accept) begin
                timer_q <= '0;
            end else if (expire) begin
                timer_q   <= '0;
                timeout_q <= 1'b1;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign timeout_pulse = timeout_q;
`else
    assign expire        = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Game FSM with registered outputs; start_pulse overrides any state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            board_q      <= '0;
            turn_q       <= 1'b0;
            winner_q     <= NONE;
            game_over_q  <= 1'b0;
            move_error_q <= 1'b0;
        end else begin
            move_error_q <= 1'b0;
            if (start_pulse) begin
                state_q     <= WAIT_MOVE;
                board_q     <= '0;
                turn_q      <= 1'b0;
                winner_q    <= NONE;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    WAIT_MOVE: begin
                        if (accept) begin
                            for (int i = 0; i < N * N; i++) begin
                                if (move_pos == PW'(i)) board_q[2*i +: 2] <= player_cell(move_player);
                            end
                            state_q <= CHECK;
                        end else begin
                            move_error_q <= move_valid;
                            if (expire) turn_q <= ~turn_q;
                        end
                    end
                    CHECK: begin
                        move_error_q <= move_valid;
                        if (line_win) begin
                            winner_q    <= line_player;
                            game_over_q <= 1'b1;
                            state_q     <= OVER;
                        end else if (board_full) begin
                            winner_q    <= DRAW;
                            game_over_q <= 1'b1;
                            state_q     <= OVER;
                        end else begin
                            turn_q  <= ~turn_q;
                            state_q <= WAIT_MOVE;
                        end
                    end
                    OVER: begin
                        move_error_q <= move_valid;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign board      = board_q;
    assign turn       = turn_q;
    assign winner     = winner_q;
    assign game_over  = game_over_q;
    assign move_error = move_error_q;

endmodule
